inst_fetch: RTL

- Instruction-fetch stage; sits directly upstream of the instruction decoder and supplies it one 32-bit instruction word per handshake.
- Owns the PC, drives the synchronous instruction BRAM (1-cycle read latency), and absorbs decoder back-pressure in a 2-entry buffer.
- Accepts branch/jump redirects from execute and flushes wrong-path words.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/fetch_buf.sv | 54 +++++
 rtl/inst_fetch.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction/IMEM widths, decoder field positions,
// the fetch buffer entry type and the fetch FSM state type.
package cpu_pkg;

  localparam int INST_W      = 32;
  localparam int IMEM_ADDR_W = 14;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RD_HI     = 25;
  localparam int RD_LO     = 21;
  localparam int RS_HI     = 20;
  localparam int RS_LO     = 16;
  localparam int RT_HI     = 15;
  localparam int RT_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMMD_HI   = 15;
  localparam int IMMD_LO   = 0;
  localparam int ADDR_HI   = 25;
  localparam int ADDR_LO   = 0;

  typedef struct packed {
    logic [INST_W-1:0]      inst;
    logic [IMEM_ADDR_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [OPCODE_HI-OPCODE_LO:0] opcode_of(input logic [INST_W-1:0] i_inst);
    return i_inst[OPCODE_HI:OPCODE_LO];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched words; absorbs decoder back-pressure.
// Flush discards all entries and wins over a same-cycle push.
module fetch_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [1:0]   o_occ,
  output fetch_entry_t o_head
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop && (r_occ != 2'd0);
  assign w_push = i_push && !i_flush;
  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // The issue rule upstream guarantees a full buffer is never pushed without a pop.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(w_push && !w_pop && r_occ == 2'd2));
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, RUN/HALT FSM, BRAM issue and redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds transfer and stall counters.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic              w_issue;
  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_demand;
  logic [1:0]        w_occ;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign inst_valid = (w_occ != 2'd0);
  assign w_pop      = inst_valid && inst_ready;
  // A redirect drops the word returning this cycle along with the buffer.
  assign w_push     = r_inflight && !redirect_valid;
  assign w_push_data.inst = imem_rdata;
  assign w_push_data.pc   = IMEM_ADDR_W'(r_inflight_pc);
  assign inst       = w_head.inst;
  assign inst_pc    = ADDR_W'(w_head.pc);
  assign imem_addr  = r_pc;
  assign imem_en    = w_issue;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_demand    = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    w_issue     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (halt) w_state_nxt = ST_HALT;
        w_issue = !rst && !redirect_valid && (w_demand < 3'd2);
      end
      ST_HALT: begin
        if (!halt) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_issue)   r_pc <= r_pc + 1'b1;
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc <= r_pc;
    end
  end

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_occ      (w_occ),
    .o_head     (w_head)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop)                     r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (inst_valid && !inst_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule
